cpu_fetch_decode: RTL and testbench

- Front end of the 4-bit CPU; sits directly upstream of the execute stage that applies the register-update operations.
- Holds the 16x8 program memory and a loader write port.
- Fetches the instruction at the IP supplied by execute, decodes it into opcode, immediate and illegal flag, and issues it over a valid/ready handshake.
- Paced by a run/step controller with a programmable issue interval.

---
 rtl/cpu_fetch_decode_if.sv | 23 ++
 rtl/cpu_fetch_decode.sv | 119 +++++++++++
 tb/tb_cpu_fetch_decode.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_fetch_decode_if.sv
// Loader write port and decoded-instruction issue channel of the CPU front end.
// master is the fetch/decode side; slave is the loader/execute side.
interface cpu_fetch_decode_if;
  logic       prog_valid;
  logic       prog_ready;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic       op_valid;
  logic       op_ready;
  logic [3:0] op_code;
  logic [3:0] op_imm;
  logic       op_illegal;

  modport master (
    input  prog_valid, prog_addr, prog_data, op_ready,
    output prog_ready, op_valid, op_code, op_imm, op_illegal
  );

  modport slave (
    output prog_valid, prog_addr, prog_data, op_ready,
    input  prog_ready, op_valid, op_code, op_imm, op_illegal
  );
endinterface

// File: rtl/cpu_fetch_decode.sv
// 4-bit CPU front end: 16x8 program memory, fetch at the execute-supplied ip,
// decode and issue over valid/ready, paced by a run/step controller.
module cpu_fetch_decode #(
  parameter int TICK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic                 step,
  input  logic [3:0]           ip,
  output logic [7:0]           retired,
  cpu_fetch_decode_if.master   bus
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, WAIT} state_t;

  localparam logic [7:0] WAIT_LOAD = 8'(TICK_DIV - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       step_q, step_d;
  logic [7:0] retired_q;
  logic [3:0] code_q, imm_q;
  logic       ill_q;
  logic [7:0] mem_q [16];
  logic       hs;
  logic       wr_en;

  function automatic logic is_illegal(input logic [3:0] op);
    case (op)
      4'h8, 4'hA, 4'hC, 4'hD: is_illegal = 1'b1;
      default:                is_illegal = 1'b0;
    endcase
  endfunction

  assign hs    = (state_q == ISSUE) && bus.op_ready;
  assign wr_en = (state_q == IDLE) && bus.prog_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    case (state_q)
      IDLE: begin
        if (run || step) begin
          state_d = FETCH;
          step_d  = step && !run;
        end
      end
      FETCH: state_d = ISSUE;
      ISSUE: begin
        if (hs) begin
          if (step_q) begin
            step_d  = 1'b0;
            state_d = IDLE;
          end else if (TICK_DIV == 1) begin
            state_d = run ? FETCH : IDLE;
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 8'd1;
        // Leaving as the counter reaches zero gives a TICK_DIV+1 cycle issue period.
        if (cnt_q <= 8'd1) state_d = run ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.op_valid   = (state_q == ISSUE);
    bus.prog_ready = (state_q == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem_q[i] <= 8'h00;
    end else if (wr_en) begin
      mem_q[bus.prog_addr] <= bus.prog_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q    <= 4'h0;
      imm_q     <= 4'h0;
      ill_q     <= 1'b0;
      retired_q <= 8'd0;
    end else begin
      if (state_q == FETCH) begin
        code_q <= mem_q[ip][7:4];
        imm_q  <= mem_q[ip][3:0];
        ill_q  <= is_illegal(mem_q[ip][7:4]);
      end
      if (hs) retired_q <= retired_q + 8'd1;
    end
  end

  assign bus.op_code    = code_q;
  assign bus.op_imm     = imm_q;
  assign bus.op_illegal = ill_q;
  assign retired        = retired_q;

endmodule

// File: tb/tb_cpu_fetch_decode.sv
// Randomized scoreboard bench for cpu_fetch_decode: stimulus pushes expected
// instruction words, a negedge monitor pops and compares on every issue.
module tb_cpu_fetch_decode;
  localparam int TD = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       run   = 1'b0;
  logic       step  = 1'b0;
  logic [3:0] ip    = 4'h0;
  logic [7:0] retired;

  cpu_fetch_decode_if bus_if();

  cpu_fetch_decode #(.TICK_DIV(TD)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .step   (step),
    .ip     (ip),
    .retired(retired),
    .bus    (bus_if.master)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int ret_m  = 0;
  logic [7:0] mem_m [16];
  logic [7:0] exp_q [$];
  logic [7:0] mon_w;
  logic [7:0] new_w;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic illegal_m(input logic [3:0] op);
    return op inside {4'h8, 4'hA, 4'hC, 4'hD};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle op_valid is high the presented word must match the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus_if.op_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_issue: op_valid=1 with code %0h imm %0h, none expected (t=%0t)",
                   bus_if.op_code, bus_if.op_imm, $time);
        end else begin
          mon_w = exp_q[0];
          chk("op_code", bus_if.op_code, mon_w[7:4]);
          chk("op_imm", bus_if.op_imm, mon_w[3:0]);
          chk("op_illegal", bus_if.op_illegal, illegal_m(mon_w[7:4]));
          if (bus_if.op_ready) begin
            chk("retired_at_hs", retired, ret_m[7:0]);
            ret_m = (ret_m + 1) % 256;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    chk("prog_ready_idle", bus_if.prog_ready, 1);
    bus_if.prog_valid = 1'b1;
    bus_if.prog_addr  = a;
    bus_if.prog_data  = d;
    tick();
    bus_if.prog_valid = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic step_one(input logic [3:0] a);
    ip = a;
    bus_if.op_ready = 1'b1;
    exp_q.push_back(mem_m[a]);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("step_fetch_novalid", bus_if.op_valid, 0);
    tick();
    chk("step_issue_valid", bus_if.op_valid, 1);
    tick();
    chk("step_done_novalid", bus_if.op_valid, 0);
    chk("step_back_idle", bus_if.prog_ready, 1);
  endtask

  task automatic wait_idle(input string name);
    for (int n = 0; n < 50 && !bus_if.prog_ready; n++) tick();
    chk(name, bus_if.prog_ready, 1);
  endtask

  task automatic free_run(input int n, input bit rand_ip, input logic [3:0] fixed_ip, input bit prog_hold);
    int cnt   = 0;
    int last  = 0;
    int guard = 0;
    ip = rand_ip ? 4'($urandom_range(15)) : fixed_ip;
    exp_q.push_back(mem_m[ip]);
    bus_if.op_ready = 1'b1;
    run = 1'b1;
    tick();
    if (prog_hold) bus_if.prog_valid = 1'b1;
    while (cnt < n && guard < n * (TD + 1) + 20) begin
      if (bus_if.prog_valid) chk("prog_ready_busy", bus_if.prog_ready, 0);
      if (bus_if.op_valid) begin
        cnt++;
        if (cnt > 1) chk("issue_period", cyc - last, TD + 1);
        last = cyc;
        if (cnt < n) begin
          if (rand_ip) ip = 4'($urandom_range(15));
          exp_q.push_back(mem_m[ip]);
        end else begin
          run = 1'b0;
        end
      end
      tick();
      guard++;
    end
    chk("free_run_count", cnt, n);
  endtask

  initial begin
    int g;
    bus_if.prog_valid = 1'b0;
    bus_if.prog_addr  = 4'h0;
    bus_if.prog_data  = 8'h00;
    bus_if.op_ready   = 1'b1;
    for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_op_valid", bus_if.op_valid, 0);
    chk("rst_op_code", bus_if.op_code, 0);
    chk("rst_op_imm", bus_if.op_imm, 0);
    chk("rst_op_illegal", bus_if.op_illegal, 0);
    chk("rst_retired", retired, 0);
    chk("rst_prog_ready", bus_if.prog_ready, 1);
    rst_n = 1'b1;
    tick();

    // Single step of a loaded program word.
    load(4'd0, 8'h35);
    load(4'd1, 8'h9F);
    step_one(4'd0);
    chk("retired_after_step", retired, 1);
    step_one(4'd1);

    for (int i = 2; i < 16; i++) load(4'(i), 8'($urandom));
    load(4'd3, 8'hC7);
    step_one(4'd3);
    chk("retired_after_illegal", retired, 3);

    // Free run at the programmed interval with random ip.
    free_run(8, 1'b1, 4'h0, 1'b0);
    wait_idle("free_run_idle");

    // Stall in ISSUE with run dropped mid-stall.
    ip = 4'($urandom_range(15));
    exp_q.push_back(mem_m[ip]);
    bus_if.op_ready = 1'b0;
    run = 1'b1;
    g = 0;
    while (!bus_if.op_valid && g < 20) begin tick(); g++; end
    for (int c = 0; c < 7; c++) begin
      chk("stall_valid_held", bus_if.op_valid, 1);
      if (c == 1) run = 1'b0;
      tick();
    end
    bus_if.op_ready = 1'b1;
    tick();
    chk("stall_release", bus_if.op_valid, 0);
    repeat (8) tick();
    chk("stall_then_idle", bus_if.prog_ready, 1);

    // Loader request held across a run: must land only once back in IDLE.
    new_w = ~mem_m[5];
    bus_if.prog_addr = 4'd5;
    bus_if.prog_data = new_w;
    free_run(4, 1'b0, 4'd5, 1'b1);
    wait_idle("prog_hold_idle");
    tick();
    bus_if.prog_valid = 1'b0;
    mem_m[5] = new_w;
    step_one(4'd5);

    // Push retired across the 255 -> 0 wrap.
    free_run(256, 1'b1, 4'h0, 1'b0);
    wait_idle("wrap_idle");
    chk("retired_after_wrap", retired, ret_m[7:0]);

    // Asynchronous reset while an issue is outstanding.
    ip = 4'd2;
    exp_q.push_back(mem_m[2]);
    bus_if.op_ready = 1'b0;
    run = 1'b1;
    g = 0;
    while (!bus_if.op_valid && g < 20) begin tick(); g++; end
    chk("pre_rst_valid", bus_if.op_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", bus_if.op_valid, 0);
    chk("rst_async_retired", retired, 0);
    chk("rst_async_code", bus_if.op_code, 0);
    exp_q.delete();
    ret_m = 0;
    for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
    run = 1'b0;
    bus_if.op_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_prog_ready", bus_if.prog_ready, 1);
    for (int a = 0; a < 16; a++) step_one(4'(a));
    chk("post_rst_retired", retired, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
